// File: rtl/pipe_stage_buf.sv
// Parametrised pipeline-stage register with valid/ready handshake, optional
// 2-entry skid buffer, flush-to-bubble and a saturating bubble counter.
module pipe_stage_buf #(
    parameter int                DATA_W   = 96,
    parameter int                CTRL_W   = 24,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
    parameter int                DEPTH    = 2,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    input  logic              stall,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both
    // high; valid never waits on ready, and stall masks the downstream ready.
    logic              dr;
    logic              acc_in;
    logic              acc_out;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;
    logic              load_m_in;
    logic              load_m_s;
    logic [1:0]        occ_nxt;

    assign dr        = out_ready & ~stall;
    assign acc_in    = in_valid & in_ready;
    assign acc_out   = m_valid & dr;
    assign load_m_in = acc_in & (~m_valid | acc_out);
    assign load_m_s  = acc_out & s_valid;

    generate
        if (DEPTH == 1) begin : g_single
            assign in_ready = ~m_valid | dr;
            assign s_valid  = 1'b0;
            assign s_data   = '0;
            assign s_ctrl   = '0;
        end else begin : g_skid
            logic load_s;

            // Ready comes straight from a flop, so out_ready never reaches in_ready.
            assign in_ready = ~s_valid;
            assign load_s   = acc_in & m_valid & ~acc_out;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s_valid <= 1'b0;
                    s_data  <= '0;
                    s_ctrl  <= CTRL_NOP;
                end else if (flush) begin
                    s_valid <= 1'b0;
                end else if (load_s) begin
                    s_valid <= 1'b1;
                    s_data  <= in_data;
                    s_ctrl  <= in_ctrl;
                end else if (acc_out) begin
                    s_valid <= 1'b0;
                end
            end
        end
    endgenerate

    // Skid entry refills M before new input; both cannot happen together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ctrl  <= CTRL_NOP;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (load_m_s) begin
            m_valid <= 1'b1;
            m_data  <= s_data;
            m_ctrl  <= s_ctrl;
        end else if (load_m_in) begin
            m_valid <= 1'b1;
            m_data  <= in_data;
            m_ctrl  <= in_ctrl;
        end else if (acc_out) begin
            m_valid <= 1'b0;
        end
    end

    always_comb begin
        occ_nxt = occupancy;
        if (flush) begin
            occ_nxt = '0;
        end else if (acc_in && !acc_out) begin
            occ_nxt = occupancy + 2'd1;
        end else if (!acc_in && acc_out) begin
            occ_nxt = occupancy - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy  <= '0;
            bubble_cnt <= '0;
        end else begin
            occupancy <= occ_nxt;
            if (!m_valid && !stall && (bubble_cnt != {CNT_W{1'b1}})) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_ctrl  = m_valid ? m_ctrl : CTRL_NOP;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three instances (skid, single register, 4-bit counter)
// driven in lockstep and compared every cycle against a FIFO reference model.
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [95:0] in_data = '0;
    logic [23:0] in_ctrl = '0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic        out_ready = 1'b0;

    logic        ir  [3];
    logic        ov  [3];
    logic [95:0] od  [3];
    logic [23:0] oc  [3];
    logic [1:0]  occ [3];
    logic [15:0] bub0, bub1;
    logic [3:0]  bub2;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: each instance is an ordered list of held entries
    int          depth_of [3] = '{2, 1, 2};
    int          cmax     [3] = '{65535, 65535, 15};
    logic [95:0] md    [3][2];
    logic [23:0] mc    [3][2];
    int          mn    [3];
    logic [95:0] mlast [3];
    int          mbub  [3];
    logic [95:0] exp_q [$];

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(96), .CTRL_W(24), .CTRL_NOP(24'h0), .DEPTH(2), .CNT_W(16)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .in_ctrl(in_ctrl), .flush(flush), .stall(stall), .out_valid(ov[0]),
        .out_ready(out_ready), .out_data(od[0]), .out_ctrl(oc[0]), .occupancy(occ[0]),
        .bubble_cnt(bub0));

    pipe_stage_buf #(.DATA_W(96), .CTRL_W(24), .CTRL_NOP(24'h0), .DEPTH(1), .CNT_W(16)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .in_ctrl(in_ctrl), .flush(flush), .stall(stall), .out_valid(ov[1]),
        .out_ready(out_ready), .out_data(od[1]), .out_ctrl(oc[1]), .occupancy(occ[1]),
        .bubble_cnt(bub1));

    pipe_stage_buf #(.DATA_W(96), .CTRL_W(24), .CTRL_NOP(24'h0), .DEPTH(2), .CNT_W(4)) u_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
        .in_ctrl(in_ctrl), .flush(flush), .stall(stall), .out_valid(ov[2]),
        .out_ready(out_ready), .out_data(od[2]), .out_ctrl(oc[2]), .occupancy(occ[2]),
        .bubble_cnt(bub2));

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic exp_ready(input int i);
        logic d;
        d = out_ready & ~stall;
        if (depth_of[i] == 2) return (mn[i] < 2);
        return (mn[i] == 0) || d;
    endfunction

    function automatic logic [95:0] bub_obs(input int i);
        if (i == 0) return {80'b0, bub0};
        if (i == 1) return {80'b0, bub1};
        return {92'b0, bub2};
    endfunction

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("i%0d_valid_t%0t", i, $time), {95'b0, ov[i]}, {95'b0, mn[i] > 0});
            chk($sformatf("i%0d_ready_t%0t", i, $time), {95'b0, ir[i]}, {95'b0, exp_ready(i)});
            chk($sformatf("i%0d_ctrl_t%0t", i, $time), {72'b0, oc[i]},
                (mn[i] > 0) ? {72'b0, mc[i][0]} : 96'h0);
            chk($sformatf("i%0d_data_t%0t", i, $time), od[i], (mn[i] > 0) ? md[i][0] : mlast[i]);
            chk($sformatf("i%0d_occ_t%0t", i, $time), {94'b0, occ[i]}, 96'(mn[i]));
            chk($sformatf("i%0d_bub_t%0t", i, $time), bub_obs(i), 96'(mbub[i]));
        end
    endtask

    // advance every model by one clock edge using the inputs currently applied
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            logic rdy, a_in, a_out, d;
            d     = out_ready & ~stall;
            rdy   = exp_ready(i);
            a_out = (mn[i] > 0) && d;
            a_in  = in_valid && rdy;
            if (mn[i] > 0) mlast[i] = md[i][0];
            if (mn[i] == 0 && !stall && mbub[i] < cmax[i]) mbub[i]++;
            if (flush) begin
                mn[i] = 0;
            end else begin
                if (a_out) begin
                    if (i == 0) begin
                        if (exp_q.size() == 0) chk("order_underflow", 96'h1, 96'h0);
                        else chk("order_d2", md[0][0], exp_q.pop_front());
                    end
                    md[i][0] = md[i][1];
                    mc[i][0] = mc[i][1];
                    mn[i]--;
                end
                if (a_in) begin
                    md[i][mn[i]] = in_data;
                    mc[i][mn[i]] = in_ctrl;
                    mn[i]++;
                    if (i == 0) exp_q.push_back(in_data);
                end
            end
            if (i == 0 && flush) exp_q.delete();
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mn[i] = 0;
            mbub[i] = 0;
            mlast[i] = '0;
        end
        exp_q.delete();
    endtask

    // driver: apply inputs just after an edge, check, then take the next edge
    task automatic cyc(input logic iv, input logic [95:0] d, input logic [23:0] c,
                       input logic fl, input logic st, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        flush     = fl;
        stall     = st;
        out_ready = ordy;
        #1;
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b1;
        in_ctrl   = 24'hABCDEF;
        in_data   = {$urandom, $urandom, $urandom};
        flush     = 1'b0;
        stall     = 1'b1;
        out_ready = 1'b1;
        rst       = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all();
    endtask

    function automatic logic [95:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [95:0] xd;
        @(posedge clk);
        #1;
        do_reset();

        // stalled idle cycles do not count; 20 unstalled ones saturate a 4-bit counter
        for (int k = 0; k < 3; k++) cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("stalled_idle_c4", {92'b0, bub2}, 96'd0);
        for (int k = 0; k < 20; k++) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("sat_c4", {92'b0, bub2}, 96'd15);
        chk("idle_d2", {80'b0, bub0}, 96'd20);

        // streaming
        for (int k = 0; k < 8; k++) cyc(1'b1, rnd96(), 24'(k + 1), 1'b0, 1'b0, 1'b1);
        chk("stream_last_valid", {95'b0, ov[0]}, 96'd1);
        chk("stream_last_ctrl", {72'b0, oc[0]}, 96'd8);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        // backpressure: A, B land, C held upstream
        cyc(1'b1, rnd96(), 24'hA, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, rnd96(), 24'hB, 1'b0, 1'b0, 1'b0);
        xd = rnd96();
        cyc(1'b1, xd, 24'hC, 1'b0, 1'b0, 1'b0);
        chk("bp_occ", {94'b0, occ[0]}, 96'd2);
        chk("bp_ready", {95'b0, ir[0]}, 96'd0);
        chk("bp_head", {72'b0, oc[0]}, 96'hA);
        cyc(1'b1, xd, 24'hC, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, xd, 24'hC, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        // flush over stall with a competing input
        cyc(1'b1, rnd96(), 24'h11, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, rnd96(), 24'h22, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, rnd96(), 24'h5A5A5A, 1'b1, 1'b1, 1'b1);
        chk("flush_valid", {95'b0, ov[0]}, 96'd0);
        chk("flush_ctrl", {72'b0, oc[0]}, 96'd0);
        chk("flush_occ", {94'b0, occ[0]}, 96'd0);
        chk("flush_ready", {95'b0, ir[0]}, 96'd1);
        for (int k = 0; k < 3; k++) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        // single-register ready follows out_ready within the cycle
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, rnd96(), 24'h77, 1'b0, 1'b0, 1'b0);
        in_valid  = 1'b0;
        stall     = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("d1_ready_low", {95'b0, ir[1]}, 96'd0);
        out_ready = 1'b1;
        #1;
        chk("d1_ready_comb", {95'b0, ir[1]}, 96'd1);
        for (int k = 0; k < 5; k++) cyc(1'b1, rnd96(), 24'(16 + k), 1'b0, 1'b0, 1'b1);
        chk("d1_thru_valid", {95'b0, ov[1]}, 96'd1);
        chk("d1_thru_ctrl", {72'b0, oc[1]}, 96'd20);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 9) < 7, rnd96(), 24'($urandom),
                $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 9) < 6);
        end

        // reset while entries are held
        cyc(1'b1, rnd96(), 24'h33, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, rnd96(), 24'h44, 1'b0, 1'b0, 1'b0);
        do_reset();
        for (int k = 0; k < 40; k++) begin
            cyc($urandom_range(0, 1) == 1, rnd96(), 24'($urandom), 1'b0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
